// File: rtl/mul_div_if.sv
// Handshake and result bus between the EX-stage issue logic and the mul/div unit.
interface mul_div_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  flush;
    logic                  start;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  stall_req;
    logic                  done;
    logic [DATA_WIDTH-1:0] result_hi;
    logic [DATA_WIDTH-1:0] result_lo;

    modport master (
        output flush, start, funct, operand_1, operand_2,
        input  stall_req, done, result_hi, result_lo
    );

    modport slave (
        input  flush, start, funct, operand_1, operand_2,
        output stall_req, done, result_hi, result_lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one radix-2 step per cycle over operand
// magnitudes, sign correction on the last step, result held on HI/LO outputs.
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        rst,
    mul_div_if.slave    bus
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [W-1:0]      mplier_q, mplier_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic              done_q, done_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;

    logic              funct_ok;
    logic              is_signed_op;
    logic              op1_neg, op2_neg;
    logic [W-1:0]      op1_mag, op2_mag;
    logic [W2-1:0]     mul_sum;
    logic [W:0]        rem_shift;
    logic [W+1:0]      rem_diff;
    logic [W2-1:0]     acc_step;
    logic [W2-1:0]     prod_fix;
    logic [W-1:0]      quo_fix, rem_fix;

    // Operand decode and one iteration step of either algorithm
    always_comb begin
        funct_ok     = (bus.funct == FN_MULT) || (bus.funct == FN_MULTU) ||
                       (bus.funct == FN_DIV)  || (bus.funct == FN_DIVU);
        is_signed_op = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
        op1_neg      = is_signed_op && bus.operand_1[W-1];
        op2_neg      = is_signed_op && bus.operand_2[W-1];
        op1_mag      = op1_neg ? -bus.operand_1 : bus.operand_1;
        op2_mag      = op2_neg ? -bus.operand_2 : bus.operand_2;

        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Restoring divide: hi half of acc is the remainder, lo half collects quotient bits
        rem_shift = {acc_q[W2-1:W], mplier_q[W-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, mcand_q[W-1:0]};
        if (!is_div_q) begin
            acc_step = mul_sum;
        end else if (!rem_diff[W+1]) begin
            acc_step = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_step = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end

        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];
        rem_fix  = neg_rem_q ? -acc_step[W2-1:W] : acc_step[W2-1:W];
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && funct_ok) begin
                        is_div_d  = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
                        neg_d     = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_CALC;
                        if (is_div_d) begin
                            mcand_d  = {W'(0), op2_mag};
                            mplier_d = op1_mag;
                        end else begin
                            mcand_d  = {W'(0), op1_mag};
                            mplier_d = op2_mag;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        mplier_d = {mplier_q[W-2:0], 1'b0};
                    end else begin
                        mplier_d = {1'b0, mplier_q[W-1:1]};
                        mcand_d  = {mcand_q[W2-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_LAST) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            hi_d = prod_fix[W2-1:W];
                            lo_d = prod_fix[W-1:0];
                        end
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Stall is combinational so the accepting instruction is held in the same cycle
    assign bus.stall_req = ((state_q == S_IDLE) && bus.start && funct_ok) ||
                           (state_q == S_CALC);
    assign bus.done      = done_q;
    assign bus.result_hi = hi_q;
    assign bus.result_lo = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: table of operations plus flush and
// reset sequences in the middle of an iteration.
module tb_mul_div_unit;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    mul_div_if #(.DATA_WIDTH(32)) bus ();

    mul_div_unit #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one op, check accept stall, 32-cycle latency, stall profile and result
    task automatic run_op(input string name, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        logic stall_bad;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct     = funct;
        bus.operand_1 = a;
        bus.operand_2 = b;
        #1;
        check({name, " accept stall"}, 64'(bus.stall_req), 64'd1);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_1 = ~a;
        bus.operand_2 = ~b;
        n         = 0;
        stall_bad = 1'b0;
        while (!bus.done && n < 40) begin
            if (!bus.stall_req) stall_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd32);
        check({name, " calc stall"}, 64'(stall_bad), 64'd0);
        check({name, " done stall"}, 64'(bus.stall_req), 64'd0);
        check({name, " hi"}, 64'(bus.result_hi), 64'(exp_hi));
        check({name, " lo"}, 64'(bus.result_lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        check({name, " done drop"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic seen_bad;

        vecs[0]  = '{"mult -3*5",        FN_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{"multu max*max",    FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"divu 100/7",       FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{"div -7/2",         FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div min/-1",       FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu by zero",     FN_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
        vecs[6]  = '{"div neg by zero",  FN_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'h00000001};
        vecs[7]  = '{"mult 7*-6",        FN_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[8]  = '{"mult min*min",     FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"div 7/-2",         FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{"multu shift",      FN_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.start     = 1'b0;
        bus.funct     = 6'h00;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset done", 64'(bus.done), 64'd0);
        check("reset stall", 64'(bus.stall_req), 64'd0);
        check("reset hi", 64'(bus.result_hi), 64'd0);
        check("reset lo", 64'(bus.result_lo), 64'd0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Flush at CALC cycle 10 of a MULT following a completed DIVU
        run_op("pre-flush divu", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct     = FN_MULT;
        bus.operand_1 = 32'd3;
        bus.operand_2 = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush stall", 64'(bus.stall_req), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        check("flush hi", 64'(bus.result_hi), 64'd2);
        check("flush lo", 64'(bus.result_lo), 64'd14);
        seen_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.stall_req) seen_bad = 1'b1;
        end
        check("flush no late done", 64'(seen_bad), 64'd0);
        run_op("post-flush mult", FN_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        // Synchronous reset in the middle of CALC
        @(negedge clk);
        bus.start     = 1'b1;
        bus.funct     = FN_MULTU;
        bus.operand_1 = 32'd9;
        bus.operand_2 = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst stall", 64'(bus.stall_req), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst hi", 64'(bus.result_hi), 64'd0);
        check("rst lo", 64'(bus.result_lo), 64'd0);

        // Non mul/div funct is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = FN_ADDU;
        #1;
        check("addu stall", 64'(bus.stall_req), 64'd0);
        seen_bad = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.stall_req) seen_bad = 1'b1;
        end
        bus.start = 1'b0;
        check("addu ignored", 64'(seen_bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide engine in the EX stage, directly downstream of ID's function-code generation.
- Executes MULT/MULTU/DIV/DIVU selected by the 6-bit funct code and produces 64-bit {hi, lo} results for the HI/LO register write.
- Raises a stall request while busy so the pipeline holds the instruction in EX until the result is ready.

Parameters:
- DATA_WIDTH, 32, operand and result half-width.
- ITERATIONS, 32, iteration cycles per operation; must equal DATA_WIDTH.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous abort from exception/flush logic.
- start  in  1  EX-stage instruction valid and targets mul/div.
- funct  in  6  function code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; any other value is ignored.
- operand_1  in  32  rs value (multiplicand / dividend).
- operand_2  in  32  rt value (multiplier / divisor).
- stall_req  out  1  hold IF/ID/EX.
- done  out  1  one-cycle result-valid pulse.
- result_hi  out  32  MULT*: product[63:32]; DIV*: remainder.
- result_lo  out  32  MULT*: product[31:0]; DIV*: quotient.

Behaviour:
- Clocking: single clock domain. rst is synchronous and active-high; rst has priority over flush, and flush has priority over everything else.
- Reset: state=IDLE, counter=0, done=0, stall_req=0, result_hi=0, result_lo=0.
- States:
  - IDLE: at an edge where start=1 and funct is one of the four codes, latch |operands| (signed ops only), the result signs and the op kind, clear the 64-bit working register, counter=0, then go to CALC.
  - CALC: one radix-2 step per cycle, counter+1. After the step with counter=31 (32nd CALC edge), apply sign correction, write result_hi/lo, go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE unconditionally. start is ignored in DONE because it is the same instruction that is now advancing.
- Latency: accept edge E0; result registered at E32; done high from E32 to E33; back in IDLE at E33.
- stall_req is combinational: 1 when (IDLE and start and funct valid) or state=CALC; 0 in DONE and in IDLE otherwise.
- Multiply: shift-add over unsigned magnitudes into a 64-bit accumulator.
  - MULT result is negated (64-bit two's complement) when the operand signs differ.
- Divide: restoring divide using a 33-bit partial remainder.
  - Signed: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (operand_2=0): still takes the full 32 cycles.
  - DIVU: lo=0xFFFFFFFF, hi=operand_1.
  - DIV: hi=operand_1 and lo=0xFFFFFFFF when operand_1>=0, lo=0x00000001 otherwise. This is deterministic; the ISA leaves it undefined.
- result_hi/result_lo hold their value until the next completion; they are not cleared by flush.
- Flush:
  - In CALC: return to IDLE next cycle with no done pulse and results unchanged.
  - In DONE: done still pulses that cycle, then IDLE.
  - In IDLE with start: the start is not accepted.
- Invalid funct with start=1 in IDLE: stays IDLE, stall_req=0.
- Operands are captured at acceptance only; changes during CALC have no effect.

Test Plan:
- MULT operand_1=0xFFFFFFFD (-3), operand_2=5 -> done at E32, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_req high from the accept cycle through the last CALC cycle, low in DONE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678 after 32 cycles.
  - DIV 0xFFFFFFF0/0 -> lo=1, hi=0xFFFFFFF0.
- Flush pulse at CALC cycle 10 of a MULT following a completed DIVU 100/7 -> IDLE next cycle, stall_req=0, no done pulse, hi/lo remain 2/14; a new start is then accepted normally.
- rst asserted mid-CALC -> next cycle all outputs 0 and state IDLE; start=1 with funct=0x21 (ADDU) -> no stall_req and no done.
